// File: rtl/alu_branch_unit.sv
// alu_branch_unit: executes one 32-bit instruction per handshake with a shift-add MUL and a HALT state.
// Define ALU_FLAGS_EN to build the {N,Z,C,V} flags register; otherwise flags is tied to zero.
module alu_branch_unit #(
    parameter int XLEN = 32,
    parameter int PC_W = 9,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [XLEN-1:0] out,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [PC_W-1:0] pc,
    output logic            result_valid,
    output logic            branch_taken,
    output logic            halted,
    output logic [3:0]      flags,
    output logic [1:0]      dbg_state
);
    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLT = 4'd5,  OP_SLL = 4'd6,  OP_SRL  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8,  OP_BEQ = 4'd9,  OP_BNE = 4'd10, OP_BLT  = 4'd11;
    localparam logic [3:0] OP_JAL  = 4'd12, OP_MUL = 4'd13, OP_HALT = 4'd15;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HALT = 2'd2} state_t;

    state_t          state_q;
    logic            rdy_q, rv_q, bt_q, halt_q;
    logic [XLEN-1:0] out_q, a_q, b_q, acc_q;
    logic [PC_W-1:0] pc_q;
    logic [RW-1:0]   rd_q;
    logic [SW-1:0]   cnt_q;
    logic [XLEN-1:0] regs_q [NREG];

    logic [3:0]      op;
    logic [RW-1:0]   rd_idx, rs1_idx, rs2_idx;
    logic [31:0]     imm32, ret32;
    logic [XLEN-1:0] rv1, rv2, opb, alu_res, mul_step;
    logic [PC_W-1:0] pc_plus1, pc_target, pc_next;
    logic            wr_en, taken, mul_last;

    assign op        = instruction[31:28];
    assign rd_idx    = instruction[23 +: RW];
    assign rs1_idx   = instruction[18 +: RW];
    assign rs2_idx   = instruction[13 +: RW];
    assign imm32     = {{19{instruction[12]}}, instruction[12:0]};
    assign rv1       = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
    assign rv2       = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];
    assign opb       = (op == OP_ADDI) ? imm32[XLEN-1:0] : rv2;
    assign pc_plus1  = pc_q + 1'b1;
    assign pc_target = pc_q + imm32[PC_W-1:0];
    assign ret32     = 32'(pc_plus1);
    assign pc_next   = taken ? pc_target : pc_plus1;

    // One shift-add step per cycle: bit cnt_q of the multiplier selects a shifted multiplicand.
    assign mul_step  = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
    assign mul_last  = (cnt_q == SW'(XLEN - 1));

    always_comb begin
        alu_res = '0;
        wr_en   = 1'b0;
        taken   = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin alu_res = rv1 + opb; wr_en = 1'b1; end
            OP_SUB:  begin alu_res = rv1 - opb; wr_en = 1'b1; end
            OP_AND:  begin alu_res = rv1 & opb; wr_en = 1'b1; end
            OP_OR:   begin alu_res = rv1 | opb; wr_en = 1'b1; end
            OP_XOR:  begin alu_res = rv1 ^ opb; wr_en = 1'b1; end
            OP_SLT:  begin alu_res = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(opb))}; wr_en = 1'b1; end
            OP_SLL:  begin alu_res = rv1 << opb[SW-1:0]; wr_en = 1'b1; end
            OP_SRL:  begin alu_res = rv1 >> opb[SW-1:0]; wr_en = 1'b1; end
            OP_BEQ:  taken = (rv1 == opb);
            OP_BNE:  taken = (rv1 != opb);
            OP_BLT:  taken = ($signed(rv1) < $signed(opb));
            OP_JAL:  begin alu_res = ret32[XLEN-1:0]; wr_en = 1'b1; taken = 1'b1; end
            default: ;
        endcase
    end

    // valid/ready: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // ready is registered, high only in IDLE, and instr_valid is a don't-care while ready is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            rv_q    <= 1'b0;
            bt_q    <= 1'b0;
            halt_q  <= 1'b0;
            out_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            rv_q <= 1'b0;
            bt_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    if (rdy_q && instr_valid) begin
                        a_q <= rv1;
                        b_q <= opb;
                        if (op == OP_MUL) begin
                            rd_q    <= rd_idx;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            rdy_q   <= 1'b0;
                            state_q <= S_MUL;
                        end else if (op == OP_HALT) begin
                            pc_q    <= pc_plus1;
                            rv_q    <= 1'b1;
                            halt_q  <= 1'b1;
                            rdy_q   <= 1'b0;
                            state_q <= S_HALT;
                        end else begin
                            if (wr_en) begin
                                out_q <= alu_res;
                                if (rd_idx != '0) regs_q[rd_idx] <= alu_res;
                            end
                            pc_q <= pc_next;
                            rv_q <= 1'b1;
                            bt_q <= taken;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_last) begin
                        out_q <= mul_step;
                        if (rd_q != '0) regs_q[rd_q] <= mul_step;
                        pc_q    <= pc_plus1;
                        rv_q    <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0]      flags_q;
    logic [XLEN:0]   add_x, sub_x;
    logic [XLEN-1:0] fl_res;
    logic            c_f, v_f, fl_we;

    always_comb begin
        add_x  = {1'b0, rv1} + {1'b0, opb};
        sub_x  = {1'b0, rv1} - {1'b0, opb};
        fl_res = alu_res;
        fl_we  = 1'b0;
        c_f    = 1'b0;
        v_f    = 1'b0;
        if (state_q == S_MUL) begin
            fl_we  = mul_last;
            fl_res = mul_step;
        end else if (state_q == S_IDLE && rdy_q && instr_valid && op <= OP_ADDI) begin
            fl_we = 1'b1;
            case (op)
                OP_ADD, OP_ADDI: begin
                    c_f = add_x[XLEN];
                    v_f = (rv1[XLEN-1] == opb[XLEN-1]) && (add_x[XLEN-1] != rv1[XLEN-1]);
                end
                OP_SUB: begin
                    c_f = ~sub_x[XLEN];
                    v_f = (rv1[XLEN-1] != opb[XLEN-1]) && (sub_x[XLEN-1] != rv1[XLEN-1]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= '0;
        else if (fl_we) flags_q <= {fl_res[XLEN-1], (fl_res == '0), c_f, v_f};
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

    assign instr_ready  = rdy_q;
    assign out          = out_q;
    assign a            = a_q;
    assign b            = b_q;
    assign pc           = pc_q;
    assign result_valid = rv_q;
    assign branch_taken = bt_q;
    assign halted       = halt_q;
    assign dbg_state    = state_q;
endmodule
